// File: rtl/operand_capture_if.sv
// Operand-capture bus: switch/button inputs and operand/status outputs.
interface operand_capture_if;
    logic [1:0] sw;
    logic       btn;
    logic       a1;
    logic       a0;
    logic       b1;
    logic       b0;
    logic       valid;
    logic       load_a_led;
    logic       load_b_led;

    modport master (
        output sw, btn,
        input  a1, a0, b1, b0, valid, load_a_led, load_b_led
    );

    modport slave (
        input  sw, btn,
        output a1, a0, b1, b0, valid, load_a_led, load_b_led
    );
endinterface

// File: rtl/operand_capture.sv
// Captures two 2-bit operands from slide switches on debounced button presses.
// Optional macro HOLD_TIMEOUT_EN adds an auto-clear after SHOW_TIMEOUT cycles in SHOW.
module operand_capture #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SHOW_TIMEOUT    = 50000000
) (
    input  logic             clk,
    input  logic             rst_n,
    operand_capture_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    if (SHOW_TIMEOUT < 1) begin : g_bad_timeout
        $error("SHOW_TIMEOUT must be at least 1");
    end

    typedef enum logic [1:0] {LOAD_A, LOAD_B, SHOW} state_t;

    state_t        state, state_nxt;
    logic [1:0]    sw_p0, sw_p1;
    logic          btn_p0, btn_p1;
    logic          btn_db;
    logic [CW-1:0] db_cnt;
    logic          press;
    logic          expire;
    logic [1:0]    a_q, b_q, a_nxt, b_nxt;

    // Stage p0/p1: two-flop synchronizers for the asynchronous board inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_p0  <= '0;
            sw_p1  <= '0;
            btn_p0 <= 1'b0;
            btn_p1 <= 1'b0;
        end else begin
            sw_p0  <= bus.sw;
            sw_p1  <= sw_p0;
            btn_p0 <= bus.btn;
            btn_p1 <= btn_p0;
        end
    end

    // Debounce: level flips only after DEBOUNCE_CYCLES consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_db <= 1'b0;
            db_cnt <= '0;
        end else if (btn_p1 == btn_db) begin
            db_cnt <= '0;
        end else if (db_cnt == CNT_LAST) begin
            btn_db <= btn_p1;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    // Press fires combinationally on the edge where the debounced level rises
    assign press = btn_p1 && !btn_db && (db_cnt == CNT_LAST);

`ifdef HOLD_TIMEOUT_EN
    localparam int TW = $clog2(SHOW_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(SHOW_TIMEOUT - 1);

    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == SHOW && state_nxt == SHOW) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign expire = (state == SHOW) && (tmo_cnt == TMO_LAST);
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD_A;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            state <= state_nxt;
            a_q   <= a_nxt;
            b_q   <= b_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        a_nxt     = a_q;
        b_nxt     = b_q;
        case (state)
            LOAD_A: begin
                if (press) begin
                    a_nxt     = sw_p1;
                    state_nxt = LOAD_B;
                end
            end
            LOAD_B: begin
                if (press) begin
                    b_nxt     = sw_p1;
                    state_nxt = SHOW;
                end
            end
            SHOW: begin
                // A press in SHOW restarts the sequence and doubles as the A load
                if (press) begin
                    a_nxt     = sw_p1;
                    b_nxt     = '0;
                    state_nxt = LOAD_B;
                end else if (expire) begin
                    a_nxt     = '0;
                    b_nxt     = '0;
                    state_nxt = LOAD_A;
                end
            end
            default: begin
                a_nxt     = '0;
                b_nxt     = '0;
                state_nxt = LOAD_A;
            end
        endcase
    end

    assign bus.a1         = a_q[1];
    assign bus.a0         = a_q[0];
    assign bus.b1         = b_q[1];
    assign bus.b0         = b_q[0];
    assign bus.valid      = (state == SHOW);
    assign bus.load_a_led = (state == LOAD_A);
    assign bus.load_b_led = (state == LOAD_B);
endmodule

// File: tb/tb_operand_capture.sv
// Bench for operand_capture: directed steps plus random button/switch activity,
// checked every cycle against a sample-history reference model.
module tb_operand_capture;
    localparam int DB = 4;
    localparam int ST = 20;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    operand_capture_if bus ();

    operand_capture #(
        .DEBOUNCE_CYCLES(DB),
        .SHOW_TIMEOUT   (ST)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: raw samples wait two edges before being seen
    bit         bq[$];
    logic [1:0] sq[$];
    int         run;
    logic       lvl;
    int         phase;      // 0: awaiting A, 1: awaiting B, 2: showing
    int         show_cnt;
    logic [1:0] ea, eb;

    function automatic logic [6:0] get_obs();
        return {bus.a1, bus.a0, bus.b1, bus.b0, bus.valid, bus.load_a_led, bus.load_b_led};
    endfunction

    function automatic logic [6:0] get_exp();
        return {ea, eb, phase == 2, phase == 0, phase == 1};
    endfunction

    task automatic model_reset();
        bq = '{1'b0, 1'b0};
        sq = '{2'b00, 2'b00};
        run = 0;
        lvl = 1'b0;
        phase = 0;
        show_cnt = 0;
        ea = 2'b00;
        eb = 2'b00;
    endtask

    task automatic model_step();
        bit         syn_b;
        logic [1:0] syn_s;
        bit         pr;
        if (!rst_n) begin
            model_reset();
            return;
        end
        syn_b = bq.pop_front();
        bq.push_back(bus.btn);
        syn_s = sq.pop_front();
        sq.push_back(bus.sw);
        pr = 1'b0;
        if (syn_b != lvl) begin
            run++;
            if (run == DB) begin
                lvl = syn_b;
                run = 0;
                pr  = syn_b;
            end
        end else begin
            run = 0;
        end
        if (pr) begin
            if (phase == 0) begin
                ea = syn_s;
                phase = 1;
            end else if (phase == 1) begin
                eb = syn_s;
                phase = 2;
            end else begin
                ea = syn_s;
                eb = 2'b00;
                phase = 1;
            end
        end
`ifdef HOLD_TIMEOUT_EN
        else if (phase == 2) begin
            show_cnt++;
            if (show_cnt == ST) begin
                ea = 2'b00;
                eb = 2'b00;
                phase = 0;
            end
        end
`endif
        if (phase != 2) show_cnt = 0;
    endtask

    task automatic check_bits(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n, input string tag);
        repeat (n) begin
            @(posedge clk);
            model_step();
            #1;
            check_bits(tag, get_obs(), get_exp());
        end
    endtask

    task automatic press(input logic [1:0] v);
        bus.sw  = v;
        bus.btn = 1'b1;
        tick(7, "press");
        bus.btn = 1'b0;
        tick(7, "release");
    endtask

    localparam logic [6:0] RST_VEC = 7'b0000_0_1_0;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        rst_n   = 1'b0;
        bus.sw  = 2'b00;
        bus.btn = 1'b0;
        tick(3, "in_reset");
        check_bits("reset_state", get_obs(), RST_VEC);
        rst_n = 1'b1;
        tick(2, "idle");

        // Clean sequence: A captured exactly DB+1 edges after first sample
        bus.sw  = 2'b10;
        bus.btn = 1'b1;
        tick(5, "debouncing");
        check_bits("before_press_edge", get_obs(), RST_VEC);
        tick(1, "press_edge");
        check_bits("capture_a", get_obs(), {2'b10, 2'b00, 1'b0, 1'b0, 1'b1});
        bus.btn = 1'b0;
        tick(8, "release_a");
        bus.sw  = 2'b01;
        bus.btn = 1'b1;
        tick(6, "press_b");
        check_bits("capture_b_valid", get_obs(), {2'b10, 2'b01, 1'b1, 1'b0, 1'b0});
        bus.btn = 1'b0;
        tick(8, "release_b");

        // Bouncing then held: one press, SHOW -> LOAD_B with A=11
        bus.sw = 2'b11;
        for (int i = 0; i < 10; i++) begin
            bus.btn = (i % 2 == 0);
            tick(1, "bounce");
        end
        bus.btn = 1'b1;
        tick(12, "held");
        check_bits("bounce_one_press", get_obs(), {2'b11, 2'b00, 1'b0, 1'b0, 1'b1});
        bus.btn = 1'b0;
        tick(8, "bounce_release");
        check_bits("release_no_event", get_obs(), {2'b11, 2'b00, 1'b0, 1'b0, 1'b1});

        // Short glitch below debounce length
        bus.sw  = 2'b00;
        bus.btn = 1'b1;
        tick(3, "glitch");
        bus.btn = 1'b0;
        tick(10, "glitch_after");
        check_bits("glitch_ignored", get_obs(), {2'b11, 2'b00, 1'b0, 1'b0, 1'b1});

        // SHOW with A=11 B=00, then re-entry loads new A
        press(2'b00);
        check_bits("show_a11_b00", get_obs(), {2'b11, 2'b00, 1'b1, 1'b0, 1'b0});
        press(2'b01);
        check_bits("show_reentry", get_obs(), {2'b01, 2'b00, 1'b0, 1'b0, 1'b1});

        // Reset asserted asynchronously in LOAD_B with A=11
        press(2'b10);
        press(2'b11);
        check_bits("load_b_a11", get_obs(), {2'b11, 2'b00, 1'b0, 1'b0, 1'b1});
        rst_n = 1'b0;
        model_reset();
        #2;
        check_bits("async_reset", get_obs(), RST_VEC);
        tick(2, "reset_hold");
        rst_n = 1'b1;
        tick(2, "post_reset");

        // Button held through reset release still yields one press
        bus.sw  = 2'b01;
        bus.btn = 1'b1;
        tick(10, "held_pre_reset");
        rst_n = 1'b0;
        model_reset();
        #2;
        check_bits("reset_while_held", get_obs(), RST_VEC);
        tick(2, "reset_held_btn");
        bus.sw = 2'b10;
        rst_n  = 1'b1;
        tick(5, "held_after_reset");
        check_bits("held_no_early_press", get_obs(), RST_VEC);
        tick(1, "held_press_edge");
        check_bits("held_one_press", get_obs(), {2'b10, 2'b00, 1'b0, 1'b0, 1'b1});
        tick(10, "still_held");
        check_bits("held_no_retrigger", get_obs(), {2'b10, 2'b00, 1'b0, 1'b0, 1'b1});
        bus.btn = 1'b0;
        tick(8, "held_release");

`ifdef HOLD_TIMEOUT_EN
        // SHOW entered 8 edges before press() returns; expiry on the 20th edge
        press(2'b11);
        tick(11, "show_wait");
        check_bits("before_expiry", get_obs(), {2'b10, 2'b11, 1'b1, 1'b0, 1'b0});
        tick(1, "expiry");
        check_bits("timeout_clear", get_obs(), RST_VEC);
        press(2'b10);
        press(2'b01);
        tick(6, "show_wait2");
        bus.sw  = 2'b11;
        bus.btn = 1'b1;
        tick(6, "press_on_expiry");
        check_bits("press_beats_expiry", get_obs(), {2'b11, 2'b00, 1'b0, 1'b0, 1'b1});
        bus.btn = 1'b0;
        tick(8, "expiry_release");
`else
        press(2'b11);
        tick(40, "show_hold");
        check_bits("show_no_timeout", get_obs(), {2'b10, 2'b11, 1'b1, 1'b0, 1'b0});
`endif

        // Random switch and button activity
        repeat (120) begin
            bus.sw  = 2'($urandom_range(0, 3));
            bus.btn = 1'($urandom_range(0, 1));
            tick($urandom_range(1, 9), "random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
